// File: rtl/trans_pkg.sv
// Shared definitions for the transaction scheduler and validator.
package trans_pkg;

    localparam int unsigned TRANS_W         = 128;
    localparam int unsigned BIT_BLOCK_START = 9;

    // Transaction layout: sender [127:80], receiver [79:32], amount [31:10], flags [9:0].
    // flags[9] is the block-start bit.
    typedef struct packed {
        logic [47:0] sender;
        logic [47:0] receiver;
        logic [21:0] amount;
        logic [9:0]  flags;
    } trans_t;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StArb      = 3'd1,
        StIssue    = 3'd2,
        StGuard    = 3'd3,
        StWaitIdle = 3'd4
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [$clog2(NREQ)-1:0] idx_o,
    output logic                    any_o
);

    int unsigned w_k;
    logic        w_found;

    // Scan requesters starting at the pointer; the first active one wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        w_found = 1'b0;
        w_k     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_k = (32'(ptr_i) + i) % NREQ;
            if (!w_found && req_i[w_k[$clog2(NREQ)-1:0]]) begin
                w_found                         = 1'b1;
                gnt_o[w_k[$clog2(NREQ)-1:0]]    = 1'b1;
                idx_o                           = w_k[$clog2(NREQ)-1:0];
            end
        end
        any_o = w_found;
    end

endmodule

// File: rtl/trans_scheduler.sv
// Round-robin front-end that feeds one transaction at a time to the validator
// and owns the block-start bit of every issued transaction.
module trans_scheduler
    import trans_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = TRANS_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 blk_start_i,
    input  logic                 val_idle_i,
    output logic [DW-1:0]        data_o,
    output logic                 valid_o,
    output logic [31:0]          txn_cnt_o,
    output logic                 blk_pend_o
);

    localparam int unsigned IW = $clog2(NREQ);

    sched_state_t  r_state;
    sched_state_t  w_state_next;
    logic [IW-1:0] r_rr_ptr;
    logic [DW-1:0] r_data;
    logic          r_valid;
    logic [31:0]   r_txn_cnt;
    logic          r_blk_pend;

    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_gnt_idx;
    logic            w_any;
    logic            w_grant_en;
    logic [DW-1:0]   w_payload;
    logic [DW-1:0]   w_issue_data;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (r_rr_ptr),
        .gnt_o (w_gnt),
        .idx_o (w_gnt_idx),
        .any_o (w_any)
    );

    assign w_payload = req_data[32'(w_gnt_idx) * DW +: DW];

    // Next-state decode; a grant happens only in ARB with at least one request.
    always_comb begin
        w_state_next = r_state;
        w_grant_en   = 1'b0;
        unique case (r_state)
            StIdle:     if (val_idle_i) w_state_next = StArb;
            StArb: begin
                if (w_any) begin
                    w_grant_en   = 1'b1;
                    w_state_next = StIssue;
                end
            end
            StIssue:    w_state_next = StGuard;
            StGuard:    w_state_next = StWaitIdle;
            StWaitIdle: if (val_idle_i) w_state_next = StArb;
            default:    w_state_next = StIdle;
        endcase
    end

    // Issue data is registered at the grant edge, so bit 9 must already reflect a
    // block-start pulse arriving in the handshake cycle; a pulse during ISSUE is
    // left pending for the next transaction instead.
    always_comb begin
        w_issue_data                  = w_payload;
        w_issue_data[BIT_BLOCK_START] = r_blk_pend | blk_start_i;
    end

    // State, pointer, registered outputs and block-start flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_rr_ptr   <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_txn_cnt  <= '0;
            r_blk_pend <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_valid <= w_grant_en;
            // Zero whenever not issuing: a stray bit 9 would reset the ledger.
            r_data  <= w_grant_en ? w_issue_data : '0;
            if (w_grant_en) begin
                r_rr_ptr <= (w_gnt_idx == IW'(NREQ - 1)) ? '0 : w_gnt_idx + IW'(1);
            end
            if (r_state == StIssue) begin
                r_txn_cnt <= r_txn_cnt + 32'd1;
            end
            if (blk_start_i) begin
                r_blk_pend <= 1'b1;
            end else if (r_state == StIssue) begin
                r_blk_pend <= 1'b0;
            end
        end
    end

    assign req_ready  = w_grant_en ? w_gnt : '0;
    assign data_o     = r_data;
    assign valid_o    = r_valid;
    assign txn_cnt_o  = r_txn_cnt;
    assign blk_pend_o = r_blk_pend;

endmodule
